// File: rtl/psx_pkg.sv
// Shared types and constants for the PSX digital pad device model.
package psx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    XFER,
    ACK_WAIT,
    ACK_PULSE,
    DONE
  } psx_state_e;

  localparam logic [7:0] PSX_START_CMD  = 8'h01;
  localparam logic [7:0] PSX_POLL_CMD   = 8'h42;
  localparam logic [7:0] PSX_READY_BYTE = 8'h5A;
  localparam logic [7:0] PSX_HIZ_BYTE   = 8'hFF;
  localparam int unsigned PSX_BYTES     = 5;

  // Reply byte for a given position in the 5-byte poll sequence.
  function automatic logic [7:0] psx_reply_byte(input logic [2:0]  idx,
                                                input logic [7:0]  dev_id,
                                                input logic [15:0] btn);
    logic [7:0] b;
    case (idx)
      3'd0:    b = PSX_HIZ_BYTE;
      3'd1:    b = dev_id;
      3'd2:    b = PSX_READY_BYTE;
      3'd3:    b = btn[7:0];
      3'd4:    b = btn[15:8];
      default: b = PSX_HIZ_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/psx_pad_device_if.sv
// PSX controller bus between host (master) and pad (slave).
interface psx_pad_device_if;
  logic psx_clk;
  logic cmd;
  logic att;
  logic data;
  logic ack;

  modport master (
    output psx_clk,
    output cmd,
    output att,
    input  data,
    input  ack
  );

  modport slave (
    input  psx_clk,
    input  cmd,
    input  att,
    output data,
    output ack
  );
endinterface

// File: rtl/psx_sync_edge.sv
// Two-flop synchroniser with registered rise/fall strobes on the synchronised level.
module psx_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;

  // Strobes compare the first and second stages so they align with the level update.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= RESET_VAL;
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= din;
      level <= s1;
      rise  <= s1 & ~level;
      fall  <= ~s1 & level;
    end
  end

endmodule

// File: rtl/psx_pad_device.sv
// PSX digital pad device: answers host polls with ID, ready and button bytes plus ack pulses.
// Optional command checking is enabled with the PSX_CMD_CHECK_EN macro.
module psx_pad_device
  import psx_pkg::*;
#(
  parameter logic [7:0]  DEV_ID    = 8'h41,
  parameter int unsigned ACK_DELAY = 4,
  parameter int unsigned ACK_WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  psx_pad_device_if.slave   bus,
  input  logic [15:0]       buttons,
  output logic              busy,
  output logic              xfer_done,
  output logic [7:0]        last_cmd
);

  localparam logic [7:0] DELAY_LAST = 8'(ACK_DELAY - 1);
  localparam logic [7:0] WIDTH_LAST = 8'(ACK_WIDTH - 1);
  localparam logic [2:0] LAST_BYTE  = 3'(PSX_BYTES - 1);

  logic clk_lvl_unused, clk_rise, clk_fall;
  logic cmd_s, cmd_rise_unused, cmd_fall_unused;
  logic att_s, att_rise, att_fall;

  psx_sync_edge #(.RESET_VAL(1'b1)) u_sync_clk (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.psx_clk),
    .level (clk_lvl_unused),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  psx_sync_edge #(.RESET_VAL(1'b1)) u_sync_cmd (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.cmd),
    .level (cmd_s),
    .rise  (cmd_rise_unused),
    .fall  (cmd_fall_unused)
  );

  // att resets low so a host still holding att low after reset yields no fall strobe;
  // a new transaction needs att to be seen high first.
  psx_sync_edge #(.RESET_VAL(1'b0)) u_sync_att (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.att),
    .level (att_s),
    .rise  (att_rise),
    .fall  (att_fall)
  );

  psx_state_e  state;
  logic        data_q;
  logic        ack_q;
  logic [3:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [7:0]  cnt;
  logic [6:0]  reply_sr;
  logic [6:0]  cmd_sr;
  logic [15:0] btn_snap;

  logic [7:0] cmd_next;
  logic [7:0] next_byte;
  logic       cmd_reject;

  assign bus.data  = data_q;
  assign bus.ack   = ack_q;
  assign cmd_next  = {cmd_s, cmd_sr};
  assign next_byte = psx_reply_byte(byte_idx + 3'd1, DEV_ID, btn_snap);

`ifdef PSX_CMD_CHECK_EN
  assign cmd_reject = ((byte_idx == 3'd0) && (cmd_next != PSX_START_CMD)) ||
                      ((byte_idx == 3'd1) && (cmd_next != PSX_POLL_CMD));
`else
  assign cmd_reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= 1'b1;
      ack_q     <= 1'b1;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      last_cmd  <= 8'h00;
      bit_cnt   <= 4'd0;
      byte_idx  <= 3'd0;
      cnt       <= 8'd0;
      reply_sr  <= '1;
      cmd_sr    <= '0;
      btn_snap  <= '1;
    end else begin
      xfer_done <= 1'b0;
      if ((state != IDLE) && att_rise) begin
        // Host abort: drop everything except the last completed command.
        state    <= IDLE;
        data_q   <= 1'b1;
        ack_q    <= 1'b1;
        busy     <= 1'b0;
        bit_cnt  <= 4'd0;
        byte_idx <= 3'd0;
        cnt      <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (att_fall) begin
              btn_snap <= buttons;
              reply_sr <= PSX_HIZ_BYTE[7:1];
              data_q   <= PSX_HIZ_BYTE[0];
              busy     <= 1'b1;
              bit_cnt  <= 4'd0;
              byte_idx <= 3'd0;
              state    <= XFER;
            end
          end

          XFER: begin
            if (clk_rise) begin
              cmd_sr  <= cmd_next[7:1];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                last_cmd <= cmd_next;
                if (cmd_reject) begin
                  data_q <= 1'b1;
                  state  <= DONE;
                end else if (byte_idx == LAST_BYTE) begin
                  xfer_done <= 1'b1;
                  data_q    <= 1'b1;
                  state     <= DONE;
                end else begin
                  cnt   <= 8'd0;
                  state <= ACK_WAIT;
                end
              end
            end else if (clk_fall && (bit_cnt != 4'd0) && (bit_cnt < 4'd8)) begin
              data_q   <= reply_sr[0];
              reply_sr <= {1'b1, reply_sr[6:1]};
            end
          end

          ACK_WAIT: begin
            if (cnt == DELAY_LAST) begin
              ack_q <= 1'b0;
              cnt   <= 8'd0;
              state <= ACK_PULSE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end

          ACK_PULSE: begin
            if (cnt == WIDTH_LAST) begin
              ack_q    <= 1'b1;
              cnt      <= 8'd0;
              byte_idx <= byte_idx + 3'd1;
              reply_sr <= next_byte[7:1];
              data_q   <= next_byte[0];
              bit_cnt  <= 4'd0;
              state    <= XFER;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end

          DONE: begin
            data_q <= 1'b1;
            ack_q  <= 1'b1;
            if (att_s) begin
              state    <= IDLE;
              busy     <= 1'b0;
              bit_cnt  <= 4'd0;
              byte_idx <= 3'd0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psx_pad_device.sv
// Directed bench for psx_pad_device: host bus model with per-scenario checking tasks.
module tb_psx_pad_device;

  localparam int         HALF = 8;
  localparam logic [7:0] DEV  = 8'h41;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] buttons;
  logic        busy;
  logic        xfer_done;
  logic [7:0]  last_cmd;

  psx_pad_device_if bus ();

  psx_pad_device #(
    .DEV_ID    (DEV),
    .ACK_DELAY (4),
    .ACK_WIDTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .buttons   (buttons),
    .busy      (busy),
    .xfer_done (xfer_done),
    .last_cmd  (last_cmd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int ack_falls = 0;

  logic [7:0] rx [5];
  logic [7:0] exp_b [5];
  int         ack_first [5];
  int         ack_lows [5];
  logic       lat2 [5];
  logic       lat3 [5];

  always @(posedge clk) if (xfer_done === 1'b1) done_cnt++;
  always @(negedge bus.ack) ack_falls++;

  // Host sends nbits of c (LSB first); samples data just before each rising edge.
  task automatic xfer_byte(input logic [7:0] c, input int nbits, input int idx,
                           output logic [7:0] r);
    r = 8'hFF;
    ack_first[idx] = 0;
    ack_lows[idx]  = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.psx_clk = 1'b0;
      bus.cmd     = c[i];
      for (int j = 1; j <= HALF; j++) begin
        @(posedge clk); #1;
        if (i == 1 && j == 2) lat2[idx] = bus.data;
        if (i == 1 && j == 3) lat3[idx] = bus.data;
      end
      @(negedge clk);
      r[i] = bus.data;
      bus.psx_clk = 1'b1;
      if (i < 7) repeat (HALF) @(negedge clk);
    end
    if (nbits == 8) begin
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        if (bus.ack === 1'b0) begin
          if (ack_first[idx] == 0) ack_first[idx] = k;
          ack_lows[idx]++;
        end
      end
    end
  endtask

  task automatic att_down();
    @(negedge clk);
    bus.att = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic att_up();
    repeat (4) @(negedge clk);
    bus.att = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [7:0] c4);
    logic [7:0] c [5];
    c = '{c0, c1, c2, c3, c4};
    att_down();
    for (int b = 0; b < 5; b++) xfer_byte(c[b], 8, b, rx[b]);
    att_up();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.data !== 1'b1) begin n_bad++; $display("FAIL reset_data got %b want 1", bus.data); end
    n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL reset_ack got %b want 1", bus.ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (xfer_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", xfer_done); end
    n_cmp++; if (last_cmd !== 8'h00) begin n_bad++; $display("FAIL reset_last_cmd got %h want 00", last_cmd); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_full_poll();
    int d0, f0;
    buttons = 16'hFFFE;
    d0 = done_cnt;
    f0 = ack_falls;
    run_txn(8'h01, 8'h42, 8'h00, 8'h00, 8'h00);
    exp_b = '{8'hFF, DEV, 8'h5A, 8'hFE, 8'hFF};
    for (int b = 0; b < 5; b++) begin
      n_cmp++;
      if (rx[b] !== exp_b[b]) begin
        n_bad++; $display("FAIL poll_byte%0d got %h want %h", b, rx[b], exp_b[b]);
      end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL poll_xfer_done got %0d want 1", done_cnt - d0); end
    n_cmp++; if (ack_falls - f0 != 4) begin n_bad++; $display("FAIL poll_ack_count got %0d want 4", ack_falls - f0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL poll_busy_end got %b want 0", busy); end
    // Byte 1 bit 0 -> bit 1 transition must land exactly 3 clocks after the pin fall.
    n_cmp++; if (lat2[1] !== DEV[0]) begin n_bad++; $display("FAIL data_latency_2 got %b want %b", lat2[1], DEV[0]); end
    n_cmp++; if (lat3[1] !== DEV[1]) begin n_bad++; $display("FAIL data_latency_3 got %b want %b", lat3[1], DEV[1]); end
  endtask

  task automatic test_ack_timing();
    buttons = 16'hFFFE;
    run_txn(8'h01, 8'h42, 8'hFF, 8'hA5, 8'h3C);
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (ack_first[b] != 7) begin n_bad++; $display("FAIL ack_delay_b%0d got %0d want 7", b, ack_first[b]); end
      n_cmp++;
      if (ack_lows[b] != 2) begin n_bad++; $display("FAIL ack_width_b%0d got %0d want 2", b, ack_lows[b]); end
    end
    n_cmp++; if (ack_lows[4] != 0) begin n_bad++; $display("FAIL ack_after_b4 got %0d want 0", ack_lows[4]); end
    n_cmp++; if (last_cmd !== 8'h3C) begin n_bad++; $display("FAIL last_cmd got %h want 3c", last_cmd); end
  endtask

  task automatic test_snapshot();
    logic [7:0] c [5];
    c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    buttons = 16'hFFFF;
    att_down();
    buttons = 16'h0000;
    for (int b = 0; b < 5; b++) xfer_byte(c[b], 8, b, rx[b]);
    att_up();
    n_cmp++; if (rx[3] !== 8'hFF) begin n_bad++; $display("FAIL snap_b3 got %h want ff", rx[3]); end
    n_cmp++; if (rx[4] !== 8'hFF) begin n_bad++; $display("FAIL snap_b4 got %h want ff", rx[4]); end
    run_txn(8'h01, 8'h42, 8'h00, 8'h00, 8'h00);
    n_cmp++; if (rx[3] !== 8'h00) begin n_bad++; $display("FAIL snap_next_b3 got %h want 00", rx[3]); end
    n_cmp++; if (rx[4] !== 8'h00) begin n_bad++; $display("FAIL snap_next_b4 got %h want 00", rx[4]); end
  endtask

  task automatic test_abort();
    int d0;
    logic [7:0] r;
    buttons = 16'h1234;
    d0 = done_cnt;
    att_down();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_start got %b want 1", busy); end
    xfer_byte(8'h01, 8, 0, r);
    xfer_byte(8'h42, 8, 1, r);
    xfer_byte(8'h00, 4, 2, r);
    @(negedge clk);
    bus.att = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (bus.data !== 1'b1) begin n_bad++; $display("FAIL abort_data got %b want 1", bus.data); end
    n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL abort_ack got %b want 1", bus.ack); end
    repeat (6) @(negedge clk);
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, d0); end
    run_txn(8'h01, 8'h42, 8'h00, 8'h00, 8'h00);
    n_cmp++; if (rx[0] !== 8'hFF) begin n_bad++; $display("FAIL abort_next_b0 got %h want ff", rx[0]); end
    n_cmp++; if (rx[3] !== 8'h34) begin n_bad++; $display("FAIL abort_next_b3 got %h want 34", rx[3]); end
    n_cmp++; if (rx[4] !== 8'h12) begin n_bad++; $display("FAIL abort_next_b4 got %h want 12", rx[4]); end
  endtask

  task automatic test_reset_mid();
    int f0;
    logic [7:0] r;
    buttons = 16'hFFFE;
    att_down();
    xfer_byte(8'h01, 8, 0, r);
    xfer_byte(8'h42, 4, 1, r);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.data !== 1'b1) begin n_bad++; $display("FAIL rstmid_data got %b want 1", bus.data); end
    n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL rstmid_ack got %b want 1", bus.ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    f0 = ack_falls;
    for (int b = 1; b < 3; b++) begin
      xfer_byte(8'h00, 8, b, r);
      n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL rstmid_quiet_b%0d got %h want ff", b, r); end
    end
    n_cmp++; if (ack_falls != f0) begin n_bad++; $display("FAIL rstmid_no_ack got %0d want %0d", ack_falls, f0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle got %b want 0", busy); end
    att_up();
    run_txn(8'h01, 8'h42, 8'h00, 8'h00, 8'h00);
    n_cmp++; if (rx[1] !== DEV) begin n_bad++; $display("FAIL rstmid_next_b1 got %h want %h", rx[1], DEV); end
    n_cmp++; if (rx[3] !== 8'hFE) begin n_bad++; $display("FAIL rstmid_next_b3 got %h want fe", rx[3]); end
  endtask

  task automatic test_cmd_check();
    int d0;
    buttons = 16'hFFFE;
    d0 = done_cnt;
    run_txn(8'h01, 8'h43, 8'h00, 8'h00, 8'h00);
    n_cmp++; if (ack_lows[0] != 2) begin n_bad++; $display("FAIL chk_ack_b0 got %0d want 2", ack_lows[0]); end
`ifdef PSX_CMD_CHECK_EN
    n_cmp++; if (ack_lows[1] != 0) begin n_bad++; $display("FAIL chk_ack_b1 got %0d want 0", ack_lows[1]); end
    n_cmp++; if (rx[3] !== 8'hFF) begin n_bad++; $display("FAIL chk_b3 got %h want ff", rx[3]); end
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL chk_done got %0d want 0", done_cnt - d0); end
`else
    n_cmp++; if (ack_lows[1] != 2) begin n_bad++; $display("FAIL chk_ack_b1 got %0d want 2", ack_lows[1]); end
    n_cmp++; if (rx[3] !== 8'hFE) begin n_bad++; $display("FAIL chk_b3 got %h want fe", rx[3]); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL chk_done got %0d want 1", done_cnt - d0); end
`endif
  endtask

  initial begin
    bus.psx_clk = 1'b1;
    bus.cmd     = 1'b1;
    bus.att     = 1'b1;
    buttons     = 16'hFFFF;
    test_reset();
    test_full_poll();
    test_ack_timing();
    test_snapshot();
    test_abort();
    test_reset_mid();
    test_cmd_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psx_pad_device.md
Name: psx_pad_device

Overview:
- Device-side model of a PSX digital pad: answers the host's att/psx_clk/cmd bus with reply bytes on data and acknowledges each byte with an active-low ack pulse.
- Sits directly downstream of the host (fake PSX) block and closes the loop so host and pad can be simulated and synthesised together on one board.
- All bus inputs are asynchronous to clk and are oversampled.

Parameters:
- DEV_ID, 8'h41, device ID byte returned in byte 1 (digital pad).
- ACK_DELAY, 4, clk cycles from end of byte to ack assertion (1..255).
- ACK_WIDTH, 2, clk cycles ack is held low (1..255).

Ports:
- clk  in  1  system clock; must be at least 8x the psx_clk rate.
- rst  in  1  synchronous, active-high reset.
- psx_clk  in  1  host serial clock; idle high.
- cmd  in  1  host command bit; LSB first.
- att  in  1  host attention; active low for the whole transaction.
- buttons  in  16  button state, active low; bit 0 = SELECT … bit 15 = SQUARE.
- data  out  1  reply bit to host; idle high.
- ack  out  1  byte acknowledge, active low; idle high.
- busy  out  1  high while a transaction is in progress.
- xfer_done  out  1  one-cycle pulse when byte 4 completes normally.
- last_cmd  out  8  most recently completed command byte.

Behaviour:
- Reset values: data=1, ack=1, busy=0, xfer_done=0, last_cmd=8'h00, state=IDLE.
- Synchronisers: psx_clk, cmd and att each pass through a 2-flop synchroniser. Edges are detected on the synchronised signals.
- Reply sequence, by byte index 0..4:
  - byte 0: 8'hFF
  - byte 1: DEV_ID
  - byte 2: 8'h5A
  - byte 3: buttons[7:0]
  - byte 4: buttons[15:8]
- Button snapshot: buttons is captured into a 16-bit register on the synchronised att falling edge. Changes to buttons during a transaction are ignored.
- IDLE:
  - On att falling: load the reply shift register with byte 0, set data = bit 0, set busy=1, clear bit and byte counters, then go to XFER.
- XFER:
  - psx_clk rising: shift the synchronised cmd into the cmd shift register (LSB first) and increment the bit counter.
  - psx_clk falling with bit counter in 1..7: drive the next reply bit on data.
  - After the 8th rising edge:
    - latch last_cmd.
    - If byte index < 4: go to ACK_WAIT.
    - If byte index = 4: pulse xfer_done, set data=1, go to DONE.
- ACK_WAIT:
  - Count ACK_DELAY cycles, then set ack=0 and go to ACK_PULSE.
- ACK_PULSE:
  - Hold ack=0 for ACK_WIDTH cycles, then set ack=1.
  - Increment byte index, load the next reply byte, drive its bit 0 on data, clear the bit counter, return to XFER.
- DONE:
  - data=1, ack=1; wait for att high, then go to IDLE with busy=0.
- Latency: data changes exactly 3 clk cycles after the pin-level psx_clk falling edge (2 sync + 1 register). ack falls ACK_DELAY+3 cycles after the 8th pin-level rising edge.
- att rising in any non-IDLE state (abort):
  - Next cycle: state=IDLE, data=1, ack=1, busy=0, no xfer_done.
  - Counters cleared. last_cmd keeps the last completed byte.
- psx_clk edges during ACK_WAIT/ACK_PULSE are ignored; they are a host protocol violation.
- Simultaneous att falling and psx_clk edge in IDLE: only att is acted on.
- rst mid-transaction: all outputs return to reset values on the next clk edge; the bus is ignored until att has been seen high.
- Counter widths: bit counter 4 bits (0..8), byte index 3 bits (0..4), delay/width counter 8 bits. No wrap occurs within legal parameter ranges.

Optional Feature:
- PSX_CMD_CHECK_EN defined:
  - If completed byte 0 != 8'h01 or byte 1 != 8'h42: no ack for that byte, data forced to 1, go to DONE.
  - Nothing more is driven until att rises.
- PSX_CMD_CHECK_EN undefined: command contents are ignored; the full 5-byte reply is always sent.

Decomposition:
- Package psx_pkg:
  - state enum (IDLE, XFER, ACK_WAIT, ACK_PULSE, DONE)
  - constants PSX_START_CMD=8'h01, PSX_POLL_CMD=8'h42, PSX_READY_BYTE=8'h5A, PSX_HIZ_BYTE=8'hFF, PSX_BYTES=5
- Sub-module: psx_sync_edge, a 2-flop synchroniser with registered rise/fall strobes, instantiated three times.

Test Plan:
- Full poll: buttons=16'hFFFE; host sends 01 42 00 00 00 -> data bytes FF 41 5A FE FF; 4 ack pulses each ACK_WIDTH cycles low; xfer_done once; last_cmd=8'h00.
- Button snapshot: buttons change from 16'hFFFF to 16'h0000 after att falls -> bytes 3/4 still FF FF; next transaction returns 00 00.
- Abort: att raised after byte 2 bit 3 -> within 3 clk cycles data=1, ack=1, busy=0; no xfer_done; next transaction starts cleanly with FF.
- Reset mid-byte 1: rst pulsed -> data=1, ack=1, busy=0 next cycle; host keeps clocking with att low -> no response until att cycles high then low.
- Ack timing: ACK_DELAY=4, ACK_WIDTH=2 -> ack low exactly 7 cycles after the 8th pin-level psx_clk rise, for exactly 2 cycles; no ack after byte 4.
- PSX_CMD_CHECK_EN defined, host sends 01 43 -> ack after byte 0 only, data stays 1 from byte 1 onward; without the macro -> the full 5-byte reply.
